glitch_filter_bank: RTL and testbench
=====================================

GLITCH_FILTER_BANK -- requirements
Module: glitch_filter_bank

Interface
REQ-001 Parameter N, default 4: number of independent channels (1..32).
REQ-002 Parameter L, default 4: counter width per channel (2..16).
REQ-003 Parameter RST_VAL, default all-ones N bits: per-channel reset level of val and cnt.
REQ-004 Parameter WITH_SYNCHRONIZER, default 1: 1 = two-flop synchroniser per channel, 0 = direct.
REQ-005 Parameter WITH_SAMP_COND, default 0: 1 = counters step only when samp_cond=1, 0 = step every cycle.
REQ-006 clk  in  1  sole clock, all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 val_in  in  N  raw asynchronous inputs.
REQ-009 samp_cond  in  1  sampling strobe, shared by all channels.
REQ-010 thr_hi  in  L  rise threshold, shared by all channels.
REQ-011 thr_lo  in  L  fall threshold, shared by all channels.
REQ-012 clr_rise  in  N  per-channel clear of sticky rise flags.
REQ-013 clr_fall  in  N  per-channel clear of sticky fall flags.
REQ-014 irq_mask  in  N  per-channel interrupt enable.
REQ-015 val  out  N  filtered level.
REQ-016 rise  out  N  one-cycle rise pulse.
REQ-017 fall  out  N  one-cycle fall pulse.
REQ-018 evt_rise  out  N  sticky rise flags.
REQ-019 evt_fall  out  N  sticky fall flags.
REQ-020 irq  out  1  registered OR of (evt_rise|evt_fall)&irq_mask.

Function
REQ-021 Each channel SHALL keep an L-bit saturating counter cnt: +1 when sampled input=1 and cnt≠all-ones, -1 when input=0 and cnt≠0, else hold; counter never wraps.
REQ-022 Sampled input SHALL be the second synchroniser stage, or val_in directly when WITH_SYNCHRONIZER=0.
REQ-023 State transitions SHALL be evaluated on the registered cnt: val 1->0 when val=1 and cnt<=thr_lo; val 0->1 when val=0 and cnt>=thr_hi; otherwise hold.
REQ-024 rise/fall SHALL be registered and asserted on the same edge val changes, high for exactly one cycle per transition.
REQ-025 thr_lo<thr_hi is required; with thr_lo>=thr_hi val SHALL still change at most once per cycle (precedence as REQ-023), no lockup.
REQ-026 thr_hi/thr_lo changes SHALL take effect on the first edge after they change; cnt is not modified.
REQ-027 thr_hi=all-ones, thr_lo=0 SHALL give pure full-count filtering with no added hysteresis.
REQ-028 evt_rise[i] SHALL be set on the edge rise[i] asserts, cleared on the edge clr_rise[i]=1; simultaneous set and clear: set wins. evt_fall likewise.
REQ-029 irq SHALL be updated every edge from current flags and mask (one-cycle latency after flag set).
REQ-030 Channels SHALL be fully independent; simultaneous events on any set of channels SHALL all be captured.

Reset
REQ-031 On rst: cnt[i]= all RST_VAL[i] bits, val=RST_VAL, rise=fall=0, evt_rise=evt_fall=0, irq=0.
REQ-032 Synchroniser flops SHALL NOT be reset; reset mid-operation SHALL abort in-progress counting with no rise/fall pulse emitted.

Structure
REQ-033 No shared package; all constants derived from parameters locally.
REQ-034 Per-channel logic (synchroniser, counter, state, pulses) SHALL live in sub-module glitch_filter_chan, instantiated N times by generate; flags and irq in the top level.

Verification (N=4, L=4, WITH_SYNCHRONIZER=1, RST_VAL=0, thr_hi=15, thr_lo=0)
REQ-035 val_in[0] 0->1 before edge 1 and held -> cnt[0]=15 after edge 17; val[0]=1 and rise[0]=1 for one cycle after edge 18; evt_rise[0]=1 after edge 18; irq=1 after edge 19 with irq_mask=0001.
REQ-036 val_in[1] high for 5 cycles then low -> cnt peaks at 5, val[1] stays 0, no rise/evt.
REQ-037 thr_hi=10, thr_lo=5, val_in[2] high from edge 1 -> val[2]=1 after edge 13; input drops after cnt saturates at 15 -> val[2]=0 and fall[2]=1 when cnt<=5 on the following edge.
REQ-038 clr_rise[0]=1 on the same edge rise[0] asserts -> evt_rise[0]=1 (set wins); clr_rise[0] on next edge -> evt_rise[0]=0, irq=0 one edge later.
REQ-039 rst asserted while cnt[3]=12, val_in[3]=1 -> after edge: cnt[3]=0, val[3]=0, all flags 0, no rise pulse.
REQ-040 WITH_SAMP_COND=1, samp_cond=1 every 4th cycle, val_in[0] high -> val[0] rises after 4x the REQ-035 count interval (±3 cycles).

Source files
------------

// File: rtl/glitch_filter_bank_if.sv
// ---------------------------------------------------------------------------
// glitch_filter_bank_if
//   Bundles every non-clock/reset signal of glitch_filter_bank.
//   master : drives raw inputs, thresholds, clears and mask (test/host side)
//   slave  : the filter bank itself, drives filtered levels, pulses, flags, irq
// Signals:
//   val_in    [N]  raw asynchronous inputs
//   samp_cond [1]  shared sampling strobe
//   thr_hi    [L]  rise threshold
//   thr_lo    [L]  fall threshold
//   clr_rise  [N]  clear sticky rise flags
//   clr_fall  [N]  clear sticky fall flags
//   irq_mask  [N]  per-channel interrupt enable
//   val       [N]  filtered level
//   rise/fall [N]  one-cycle transition pulses
//   evt_rise/evt_fall [N] sticky event flags
//   irq       [1]  registered interrupt
// ---------------------------------------------------------------------------
interface glitch_filter_bank_if #(
    parameter int N = 4,
    parameter int L = 4
);
    logic [N-1:0] val_in;
    logic         samp_cond;
    logic [L-1:0] thr_hi;
    logic [L-1:0] thr_lo;
    logic [N-1:0] clr_rise;
    logic [N-1:0] clr_fall;
    logic [N-1:0] irq_mask;
    logic [N-1:0] val;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] evt_rise;
    logic [N-1:0] evt_fall;
    logic         irq;

    modport master (
        output val_in, samp_cond, thr_hi, thr_lo, clr_rise, clr_fall, irq_mask,
        input  val, rise, fall, evt_rise, evt_fall, irq
    );

    modport slave (
        input  val_in, samp_cond, thr_hi, thr_lo, clr_rise, clr_fall, irq_mask,
        output val, rise, fall, evt_rise, evt_fall, irq
    );
endinterface

// File: rtl/glitch_filter_bank_chan.sv
// ---------------------------------------------------------------------------
// glitch_filter_chan
//   One filter channel: optional two-flop synchroniser, L-bit saturating
//   up/down counter, two-state level FSM with hysteresis thresholds, and
//   registered one-cycle rise/fall pulses.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   val_in          raw asynchronous input bit
//   samp_cond       counter step enable (used only when WITH_SAMP_COND=1)
//   thr_hi, thr_lo  rise / fall thresholds, compared against registered cnt
//   val             filtered level
//   rise, fall      registered one-cycle pulses, aligned with val change
//   rise_set        combinational: val goes 0->1 on the coming edge
//   fall_set        combinational: val goes 1->0 on the coming edge
// ---------------------------------------------------------------------------
module glitch_filter_chan #(
    parameter int L                 = 4,
    parameter bit RST_BIT           = 1'b1,
    parameter bit WITH_SYNCHRONIZER = 1'b1,
    parameter bit WITH_SAMP_COND    = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         val_in,
    input  logic         samp_cond,
    input  logic [L-1:0] thr_hi,
    input  logic [L-1:0] thr_lo,
    output logic         val,
    output logic         rise,
    output logic         fall,
    output logic         rise_set,
    output logic         fall_set
);
    localparam logic [L-1:0] CNT_MAX = {L{1'b1}};
    localparam logic [L-1:0] CNT_RST = {L{RST_BIT}};

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } state_t;

    localparam state_t ST_RST = RST_BIT ? ST_HIGH : ST_LOW;

    logic         smp;
    logic         step;
    logic [L-1:0] cnt_q, cnt_d;
    state_t       st_q, st_d;
    logic         rise_q, fall_q;

    // Synchroniser flops are deliberately left out of reset: they only carry
    // the external level and must keep sampling while the rest is held.
    generate
        if (WITH_SYNCHRONIZER) begin : g_sync
            logic sync1, sync2;
            always_ff @(posedge clk) begin
                sync1 <= val_in;
                sync2 <= sync1;
            end
            assign smp = sync2;
        end else begin : g_direct
            assign smp = val_in;
        end
    endgenerate

    assign step = WITH_SAMP_COND ? samp_cond : 1'b1;

    // Saturating counter: never wraps in either direction.
    always_comb begin
        cnt_d = cnt_q;
        if (step) begin
            if (smp && (cnt_q != CNT_MAX))
                cnt_d = cnt_q + 1'b1;
            else if (!smp && (cnt_q != '0))
                cnt_d = cnt_q - 1'b1;
        end
    end

    // Level FSM evaluates the registered count, so a threshold change is
    // seen on the very next edge. Only one transition per state, so even an
    // inverted threshold pair (thr_lo >= thr_hi) toggles at most once a cycle.
    always_comb begin
        st_d     = st_q;
        rise_set = 1'b0;
        fall_set = 1'b0;
        case (st_q)
            ST_LOW: begin
                if (cnt_q >= thr_hi) begin
                    st_d     = ST_HIGH;
                    rise_set = 1'b1;
                end
            end
            ST_HIGH: begin
                if (cnt_q <= thr_lo) begin
                    st_d     = ST_LOW;
                    fall_set = 1'b1;
                end
            end
            default: st_d = ST_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= CNT_RST;
            st_q   <= ST_RST;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            st_q   <= st_d;
            rise_q <= rise_set;
            fall_q <= fall_set;
        end
    end

    assign val  = (st_q == ST_HIGH);
    assign rise = rise_q;
    assign fall = fall_q;
endmodule

// File: rtl/glitch_filter_bank.sv
// ---------------------------------------------------------------------------
// glitch_filter_bank
//   N independent debounce/glitch filter channels with hysteresis, plus
//   sticky per-channel event flags and a masked, registered interrupt.
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset
//   bus   glitch_filter_bank_if.slave: raw inputs, thresholds, clears, mask
//         in; filtered levels, pulses, sticky flags, irq out
// ---------------------------------------------------------------------------
module glitch_filter_bank #(
    parameter int           N                 = 4,
    parameter int           L                 = 4,
    parameter logic [N-1:0] RST_VAL           = {N{1'b1}},
    parameter bit           WITH_SYNCHRONIZER = 1'b1,
    parameter bit           WITH_SAMP_COND    = 1'b0
) (
    input logic                 clk,
    input logic                 rst,
    glitch_filter_bank_if.slave bus
);
    logic [N-1:0] val_w, rise_w, fall_w;
    logic [N-1:0] rise_set, fall_set;
    logic [N-1:0] evt_rise_q, evt_fall_q;
    logic         irq_q;

    generate
        for (genvar i = 0; i < N; i++) begin : g_chan
            glitch_filter_chan #(
                .L                 (L),
                .RST_BIT           (RST_VAL[i]),
                .WITH_SYNCHRONIZER (WITH_SYNCHRONIZER),
                .WITH_SAMP_COND    (WITH_SAMP_COND)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .val_in    (bus.val_in[i]),
                .samp_cond (bus.samp_cond),
                .thr_hi    (bus.thr_hi),
                .thr_lo    (bus.thr_lo),
                .val       (val_w[i]),
                .rise      (rise_w[i]),
                .fall      (fall_w[i]),
                .rise_set  (rise_set[i]),
                .fall_set  (fall_set[i])
            );
        end
    endgenerate

    // Flags are set from the channel's next-edge transition so they land on
    // the same edge as the pulse; set has priority over a same-cycle clear.
    // irq looks at the flags as they stand, giving one cycle of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_rise_q <= '0;
            evt_fall_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            evt_rise_q <= (evt_rise_q & ~bus.clr_rise) | rise_set;
            evt_fall_q <= (evt_fall_q & ~bus.clr_fall) | fall_set;
            irq_q      <= |((evt_rise_q | evt_fall_q) & bus.irq_mask);
        end
    end

    assign bus.val      = val_w;
    assign bus.rise     = rise_w;
    assign bus.fall     = fall_w;
    assign bus.evt_rise = evt_rise_q;
    assign bus.evt_fall = evt_fall_q;
    assign bus.irq      = irq_q;
endmodule

// File: tb/tb_glitch_filter_bank.sv
module tb_glitch_filter_bank;
    typedef struct packed {
        logic [3:0] val;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] er;
        logic [3:0] ef;
        logic       irq;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    glitch_filter_bank_if #(.N(4), .L(4)) if0 ();
    glitch_filter_bank_if #(.N(4), .L(4)) if1 ();

    // dut0: defaults (all-ones reset, synchroniser, step every cycle)
    glitch_filter_bank #(
        .N(4), .L(4), .RST_VAL(4'hF), .WITH_SYNCHRONIZER(1'b1), .WITH_SAMP_COND(1'b0)
    ) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

    // dut1: mixed reset levels, direct input, strobe-gated counting
    glitch_filter_bank #(
        .N(4), .L(4), .RST_VAL(4'h6), .WITH_SYNCHRONIZER(1'b0), .WITH_SAMP_COND(1'b1)
    ) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    // shared stimulus
    logic [3:0] vin = '0, clr_r = '0, clr_f = '0, mask = '0;
    logic       samp = 1'b0;
    logic [3:0] thi = 4'd15, tlo = 4'd0;

    always_comb begin
        if0.val_in = vin;  if0.samp_cond = samp; if0.thr_hi = thi; if0.thr_lo = tlo;
        if0.clr_rise = clr_r; if0.clr_fall = clr_f; if0.irq_mask = mask;
        if1.val_in = vin;  if1.samp_cond = samp; if1.thr_hi = thi; if1.thr_lo = tlo;
        if1.clr_rise = clr_r; if1.clr_fall = clr_f; if1.irq_mask = mask;
    end

    // reference model: integer counters, boolean levels, input history
    int         mcnt [2][4];
    logic [3:0] mv  [2];
    logic [3:0] mer [2];
    logic [3:0] mef [2];
    logic [3:0] rv  [2] = '{4'hF, 4'h6};
    logic [3:0] h1 = '0, h2 = '0;   // vin seen one / two edges ago
    obs_t       q [2][$];

    int checks = 0;
    int errors = 0;

    task automatic model_step(input int d);
        obs_t       e;
        logic [3:0] smp;
        bit         step;
        bit         r, f;
        smp  = (d == 0) ? h2 : vin;       // two-edge delay through the synchroniser
        step = (d == 0) ? 1'b1 : samp;
        e    = '0;
        e.irq = rst ? 1'b0 : |((mer[d] | mef[d]) & mask);
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                mcnt[d][i] = rv[d][i] ? 15 : 0;
                mv[d][i]   = rv[d][i];
                mer[d][i]  = 1'b0;
                mef[d][i]  = 1'b0;
            end else begin
                r = !mv[d][i] && (mcnt[d][i] >= int'(thi));
                f =  mv[d][i] && (mcnt[d][i] <= int'(tlo));
                if (r) mv[d][i] = 1'b1;
                if (f) mv[d][i] = 1'b0;
                if (step) begin
                    if (smp[i]) mcnt[d][i] = (mcnt[d][i] < 15) ? mcnt[d][i] + 1 : 15;
                    else        mcnt[d][i] = (mcnt[d][i] > 0)  ? mcnt[d][i] - 1 : 0;
                end
                mer[d][i] = (mer[d][i] & !clr_r[i]) | r;
                mef[d][i] = (mef[d][i] & !clr_f[i]) | f;
                e.rise[i] = r;
                e.fall[i] = f;
            end
        end
        e.val = mv[d];
        e.er  = mer[d];
        e.ef  = mef[d];
        q[d].push_back(e);
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        h2 = h1;
        h1 = vin;
    end

    task automatic cmp(input string nm, input int d, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL dut%0d %s got %b exp %b at %0t", d, nm, got, exp, $time);
        end
    endtask

    task automatic check_obs(input int d, input obs_t e, input obs_t g);
        cmp("val", d, g.val, e.val);
        cmp("rise", d, g.rise, e.rise);
        cmp("fall", d, g.fall, e.fall);
        cmp("evt_rise", d, g.er, e.er);
        cmp("evt_fall", d, g.ef, e.ef);
        cmp("irq", d, {3'b0, g.irq}, {3'b0, e.irq});
    endtask

    // monitor: outputs are sampled mid-cycle, away from the active edge
    always @(negedge clk) begin
        obs_t e, g;
        if (q[0].size() > 0) begin
            e = q[0].pop_front();
            g = '{if0.val, if0.rise, if0.fall, if0.evt_rise, if0.evt_fall, if0.irq};
            check_obs(0, e, g);
        end
        if (q[1].size() > 0) begin
            e = q[1].pop_front();
            g = '{if1.val, if1.rise, if1.fall, if1.evt_rise, if1.evt_fall, if1.irq};
            check_obs(1, e, g);
        end
    end

    initial begin
        int len, p, smode, tsel, cyc;
        cyc = 0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        for (int seg = 0; seg < 120; seg++) begin
            len   = $urandom_range(40, 5);
            case ($urandom_range(3, 0))
                0: p = 2;
                1: p = 8;
                2: p = 30;
                default: p = 1000;
            endcase
            smode = $urandom_range(2, 0);
            mask  = 4'($urandom);
            tsel  = $urandom_range(5, 0);
            if (tsel == 0)      begin thi = 4'd15; tlo = 4'd0; end
            else if (tsel == 1) begin thi = 4'd10; tlo = 4'd5; end
            else if (tsel == 2) begin thi = 4'($urandom); tlo = 4'($urandom); end
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                cyc++;
                for (int i = 0; i < 4; i++)
                    if ($urandom_range(p - 1, 0) == 0) vin[i] = ~vin[i];
                clr_r = 4'($urandom & $urandom & $urandom);
                clr_f = 4'($urandom & $urandom & $urandom);
                case (smode)
                    0: samp = 1'b1;
                    1: samp = 1'($urandom);
                    default: samp = ((cyc % 4) == 0);
                endcase
                rst = ($urandom_range(199, 0) == 0);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
